vlsu_store_seq: RTL and testbench

//  Vector store sequencer in the VLSU, directly upstream of the store/bank-write stage.

---
 rtl/vlsu_store_seq_pkg.sv | 18 +
 rtl/vlsu_store_seq_if.sv | 30 +++
 rtl/vlsu_store_seq_group_sel.sv | 39 +++
 rtl/vlsu_store_seq.sv | 110 +++++++++++
 tb/tb_vlsu_store_seq.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/vlsu_store_seq_pkg.sv
// Shared types and constants for the vector store sequencer.
package vlsu_store_seq_pkg;

    // Number of write lanes. Each lane is tied to one bank, addr[1:0].
    localparam int VSQ_LANES = 4;

    typedef enum logic [1:0] {
        VSQ_IDLE  = 2'd0,
        VSQ_ISSUE = 2'd1,
        VSQ_DONE  = 2'd2
    } vsq_state_e;

    // Counts the elements in a 4-bit accept mask.
    function automatic logic [2:0] vsq_popcnt4(input logic [3:0] m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/vlsu_store_seq_if.sv
// Request, VRF read and bank-write bus between the vector controller and the store sequencer.
interface vlsu_store_seq_if #(
    parameter int ADDR_W = 12,
    parameter int VL_W   = 6
);
    import vlsu_store_seq_pkg::*;

    logic                                start;
    logic [ADDR_W-1:0]                   base_addr;
    logic [ADDR_W-1:0]                   stride;
    logic [VL_W-1:0]                     vl;
    logic                                stall;
    logic [VL_W-1:0]                     vrf_idx;
    logic [VSQ_LANES-1:0][31:0]          vrf_data;
    logic                                is_vstype;
    logic [VSQ_LANES-1:0][31:0]          vs_data;
    logic [VSQ_LANES-1:0][ADDR_W-1:0]    vs_addr;
    logic                                busy;
    logic                                done;

    modport slave (
        input  start, base_addr, stride, vl, stall, vrf_data,
        output vrf_idx, is_vstype, vs_data, vs_addr, busy, done
    );

    modport master (
        output start, base_addr, stride, vl, stall, vrf_data,
        input  vrf_idx, is_vstype, vs_data, vs_addr, busy, done
    );
endinterface

// File: rtl/vlsu_store_seq_group_sel.sv
// Picks the largest issuable group from the current 4-element window:
// a prefix that stays in the row of its first element and hits distinct banks.
module vsq_group_sel
    import vlsu_store_seq_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int VL_W   = 6
) (
    input  logic [ADDR_W-1:0]                 base_i,
    input  logic [ADDR_W-1:0]                 stride_i,
    input  logic [VL_W-1:0]                   cursor_i,
    input  logic [VL_W-1:0]                   remain_i,
    output logic [VSQ_LANES-1:0]              accept_o,
    output logic [VSQ_LANES-1:0][1:0]         lane_o,
    output logic [VSQ_LANES-1:0][ADDR_W-1:0]  addr_o,
    output logic [2:0]                        size_o
);
    logic run;

    // Element addresses wrap modulo 2**ADDR_W; acceptance stops at the first conflict.
    always_comb begin
        accept_o = '0;
        lane_o   = '0;
        addr_o   = '0;
        run      = 1'b1;
        for (int j = 0; j < VSQ_LANES; j++) begin
            addr_o[j] = base_i + (ADDR_W'(cursor_i) + ADDR_W'(j)) * stride_i;
            lane_o[j] = addr_o[j][1:0];
        end
        for (int j = 0; j < VSQ_LANES; j++) begin
            run = run && (VL_W'(j) < remain_i)
                      && (addr_o[j][ADDR_W-1:2] == addr_o[0][ADDR_W-1:2]);
            for (int p = 0; p < j; p++)
                if (lane_o[p] == lane_o[j]) run = 1'b0;
            accept_o[j] = run;
        end
        size_o = vsq_popcnt4(accept_o);
    end
endmodule

// File: rtl/vlsu_store_seq.sv
// Vector store sequencer: walks a strided store four VRF elements at a time and
// presents each bank-conflict-free group on the per-bank write lanes one cycle later.
module vlsu_store_seq
    import vlsu_store_seq_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int VL_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    vlsu_store_seq_if.slave   bus
);
    vsq_state_e                        state_q, state_d;
    logic [VL_W-1:0]                   cursor_q, cursor_d;
    logic [ADDR_W-1:0]                 base_q, stride_q;
    logic [VL_W-1:0]                   vl_q;
    logic                              is_vstype_q;
    logic [VSQ_LANES-1:0][31:0]        vs_data_q, vs_data_d;
    logic [VSQ_LANES-1:0][ADDR_W-1:0]  vs_addr_q, vs_addr_d;
    logic                              load_req, issue;

    logic [VSQ_LANES-1:0]              accept;
    logic [VSQ_LANES-1:0][1:0]         lane;
    logic [VSQ_LANES-1:0][ADDR_W-1:0]  addr;
    logic [2:0]                        size;

    vsq_group_sel #(.ADDR_W(ADDR_W), .VL_W(VL_W)) u_sel (
        .base_i   (base_q),
        .stride_i (stride_q),
        .cursor_i (cursor_q),
        .remain_i (vl_q - cursor_q),
        .accept_o (accept),
        .lane_o   (lane),
        .addr_o   (addr),
        .size_o   (size)
    );

    // Next state, cursor advance and request capture; a stall freezes everything.
    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        load_req = 1'b0;
        issue    = 1'b0;
        if (!bus.stall) begin
            case (state_q)
                VSQ_IDLE: if (bus.start) begin
                    load_req = 1'b1;
                    cursor_d = '0;
                    state_d  = (bus.vl == '0) ? VSQ_DONE : VSQ_ISSUE;
                end
                VSQ_ISSUE: begin
                    issue    = 1'b1;
                    cursor_d = cursor_q + VL_W'(size);
                    if (cursor_d == vl_q) state_d = VSQ_DONE;
                end
                VSQ_DONE: state_d = VSQ_IDLE;
                default:  state_d = VSQ_IDLE;
            endcase
        end
    end

    // Lane steering: accepted elements land on their bank; idle lanes keep the
    // group row but carry mismatching bank bits so they never write.
    always_comb begin
        for (int k = 0; k < VSQ_LANES; k++) begin
            vs_addr_d[k] = {addr[0][ADDR_W-1:2], 2'(k) ^ 2'b01};
            vs_data_d[k] = '0;
        end
        for (int j = 0; j < VSQ_LANES; j++) begin
            if (accept[j]) begin
                vs_addr_d[lane[j]] = addr[j];
                vs_data_d[lane[j]] = bus.vrf_data[j];
            end
        end
    end

    // State, request and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= VSQ_IDLE;
            cursor_q    <= '0;
            base_q      <= '0;
            stride_q    <= '0;
            vl_q        <= '0;
            is_vstype_q <= 1'b0;
            vs_data_q   <= '0;
            vs_addr_q   <= '0;
        end else if (!bus.stall) begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            is_vstype_q <= issue;
            if (load_req) begin
                base_q   <= bus.base_addr;
                stride_q <= bus.stride;
                vl_q     <= bus.vl;
            end
            if (issue) begin
                vs_data_q <= vs_data_d;
                vs_addr_q <= vs_addr_d;
            end
        end
    end

    assign bus.vrf_idx   = cursor_q;
    assign bus.is_vstype = is_vstype_q;
    assign bus.vs_data   = vs_data_q;
    assign bus.vs_addr   = vs_addr_q;
    assign bus.busy      = (state_q != VSQ_IDLE);
    assign bus.done      = (state_q == VSQ_DONE);
endmodule

// File: tb/tb_vlsu_store_seq.sv
// Directed bench for the vector store sequencer with a group scoreboard.
module tb_vlsu_store_seq;
    import vlsu_store_seq_pkg::*;

    localparam int ADDR_W = 12;
    localparam int VL_W   = 6;

    typedef struct packed {
        logic [3:0][ADDR_W-1:0] addr;
        logic [3:0][31:0]       data;
    } grp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    grp_t exp_q[$];

    always #5 clk = ~clk;

    vlsu_store_seq_if #(.ADDR_W(ADDR_W), .VL_W(VL_W)) bus ();

    vlsu_store_seq #(.ADDR_W(ADDR_W), .VL_W(VL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] vrf_val(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // VRF model: combinational read of four consecutive elements.
    always_comb
        for (int j = 0; j < 4; j++) bus.vrf_data[j] = vrf_val(int'(bus.vrf_idx) + j);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: greedy grouping straight from the element address formula.
    task automatic push_model(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                              input int vl, output int ngrp);
        int cur;
        cur  = 0;
        ngrp = 0;
        while (cur < vl) begin
            grp_t g;
            logic [ADDR_W-1:0] a0, a;
            logic [3:0] used;
            int take;
            a0 = base + ADDR_W'(cur) * stride;
            for (int k = 0; k < 4; k++) begin
                g.addr[k] = {a0[ADDR_W-1:2], 2'(k) ^ 2'b01};
                g.data[k] = '0;
            end
            used = '0;
            take = 0;
            for (int j = 0; j < 4; j++) begin
                if (cur + j >= vl) break;
                a = base + ADDR_W'(cur + j) * stride;
                if (a[ADDR_W-1:2] != a0[ADDR_W-1:2] || used[a[1:0]]) break;
                used[a[1:0]]   = 1'b1;
                g.addr[a[1:0]] = a;
                g.data[a[1:0]] = vrf_val(cur + j);
                take++;
            end
            exp_q.push_back(g);
            cur += take;
            ngrp++;
        end
    endtask

    task automatic cmp_grp(input string tag);
        grp_t g;
        chk({tag, "_pending"}, 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
            g = exp_q.pop_front();
            chk({tag, "_addr"}, 128'(bus.vs_addr), 128'(g.addr));
            chk({tag, "_data"}, 128'(bus.vs_data), 128'(g.data));
        end
    endtask

    task automatic run_op(input string tag, input logic [ADDR_W-1:0] base,
                          input logic [ADDR_W-1:0] stride, input int vl);
        int ng, done_at;
        push_model(base, stride, vl, ng);
        @(negedge clk);
        bus.base_addr = base;
        bus.stride    = stride;
        bus.vl        = VL_W'(vl);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_busy"}, 128'(bus.busy), 128'(1));
        done_at = -1;
        for (int it = 0; it < 40; it++) begin
            if (bus.is_vstype) cmp_grp(tag);
            if (bus.done) begin
                done_at = it;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done_cycle"}, 128'(done_at), 128'(ng));
        chk({tag, "_all_groups"}, 128'(exp_q.size()), 128'(0));
        @(negedge clk);
        chk({tag, "_idle"}, 128'({bus.busy, bus.done, bus.is_vstype}), 128'(0));
        exp_q.delete();
    endtask

    initial begin
        int ng;
        grp_t g1;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.stride    = '0;
        bus.vl        = '0;
        bus.stall     = 1'b0;
        #2;
        chk("reset_ctl", 128'({bus.busy, bus.done, bus.is_vstype}), 128'(0));
        chk("reset_idx", 128'(bus.vrf_idx), 128'(0));
        chk("reset_addr", 128'(bus.vs_addr), 128'(0));
        chk("reset_data", 128'(bus.vs_data), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("unit_aligned", 12'h040, 12'h001, 8);
        run_op("unit_offset",  12'h041, 12'h001, 4);
        run_op("stride4",      12'h082, 12'h004, 3);
        run_op("neg1",         12'h003, 12'hFFF, 4);
        run_op("stride0",      12'h020, 12'h000, 3);
        run_op("neg_wrap",     12'h001, 12'hFFE, 3);
        run_op("vl_zero",      12'h010, 12'h001, 0);
        run_op("vl_max",       12'h3F0, 12'h001, 63);

        // Start arriving while DONE is presented must be dropped.
        @(negedge clk);
        bus.base_addr = 12'h200;
        bus.stride    = 12'h001;
        bus.vl        = '0;
        bus.start     = 1'b1;
        @(negedge clk);
        chk("busy_start_done", 128'({bus.busy, bus.done}), 128'(2'b11));
        bus.vl = VL_W'(4);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_start_ignored", 128'({bus.busy, bus.is_vstype}), 128'(0));
        @(negedge clk);
        chk("busy_start_still_idle", 128'({bus.busy, bus.is_vstype}), 128'(0));

        // Stall freezes a presented group, then reset aborts the operation.
        push_model(12'h100, 12'h001, 16, ng);
        g1 = exp_q[0];
        @(negedge clk);
        bus.base_addr = 12'h100;
        bus.stride    = 12'h001;
        bus.vl        = VL_W'(16);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("stall_g1_vld", 128'(bus.is_vstype), 128'(1));
        cmp_grp("stall_g1");
        chk("stall_idx0", 128'(bus.vrf_idx), 128'(4));
        bus.stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("stall_hold_vld", 128'({bus.is_vstype, bus.busy}), 128'(2'b11));
            chk("stall_hold_addr", 128'(bus.vs_addr), 128'(g1.addr));
            chk("stall_hold_data", 128'(bus.vs_data), 128'(g1.data));
            chk("stall_hold_idx", 128'(bus.vrf_idx), 128'(4));
        end
        bus.stall = 1'b0;
        @(negedge clk);
        cmp_grp("stall_g2");
        chk("stall_idx1", 128'(bus.vrf_idx), 128'(8));
        #2 rst = 1'b1;
        #1;
        chk("arst_ctl", 128'({bus.busy, bus.done, bus.is_vstype}), 128'(0));
        chk("arst_addr", 128'(bus.vs_addr), 128'(0));
        chk("arst_data", 128'(bus.vs_data), 128'(0));
        chk("arst_idx", 128'(bus.vrf_idx), 128'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_stays_idle", 128'({bus.busy, bus.is_vstype}), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
